// File: rtl/order_gen_pkg.sv
// Shared strategy-path constants: FSM state encoding, side encoding and default risk limits.
package order_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SEND  = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  localparam int DEF_ORDER_QTY = 1;
  localparam int DEF_MAX_POS   = 1000;
  localparam int DEF_COOLDOWN  = 8;

endpackage

// File: rtl/order_gen_if.sv
// Decision, market-data and order-handshake signals between the strategy side and order_gen.
interface order_gen_if #(
  parameter int W     = 32,
  parameter int QTY_W = 16,
  parameter int ID_W  = 16
);
  logic                dec_valid;
  logic                dec_buy;
  logic                dec_sell;
  logic [W-1:0]        bid_px0;
  logic [W-1:0]        ask_px0;
  logic signed [W-1:0] inventory;
  logic                kill;
  logic                ord_valid;
  logic                ord_ready;
  logic                ord_side;
  logic [W-1:0]        ord_px;
  logic [QTY_W-1:0]    ord_qty;
  logic [ID_W-1:0]     ord_id;
  logic                busy;
  logic [15:0]         drop_cnt;

  modport master (
    output dec_valid, dec_buy, dec_sell, bid_px0, ask_px0, inventory, kill, ord_ready,
    input  ord_valid, ord_side, ord_px, ord_qty, ord_id, busy, drop_cnt
  );

  modport slave (
    input  dec_valid, dec_buy, dec_sell, bid_px0, ask_px0, inventory, kill, ord_ready,
    output ord_valid, ord_side, ord_px, ord_qty, ord_id, busy, drop_cnt
  );
endinterface

// File: rtl/order_gen.sv
// Turns strategy decisions into risk-checked, rate-limited orders with a valid/ready handshake.
module order_gen
  import order_gen_pkg::*;
#(
  parameter int W         = 32,
  parameter int QTY_W     = 16,
  parameter int ID_W      = 16,
  parameter int ORDER_QTY = DEF_ORDER_QTY,
  parameter int MAX_POS   = DEF_MAX_POS,
  parameter int COOLDOWN  = DEF_COOLDOWN
) (
  input logic       clk,
  input logic       rst,
  order_gen_if.slave bus
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic signed [W:0] P_LIM = (W+1)'(MAX_POS);
  localparam logic signed [W:0] P_QTY = (W+1)'(ORDER_QTY);

  state_t              r_state;
  logic                r_side;
  logic [W-1:0]        r_px;
  logic signed [W-1:0] r_inv;
  logic [CW-1:0]       r_cool;
  logic                r_ord_valid;
  logic                r_ord_side;
  logic [W-1:0]        r_ord_px;
  logic [QTY_W-1:0]    r_ord_qty;
  logic [ID_W-1:0]     r_ord_id;
  logic                r_busy;
  logic [15:0]         r_drop;

  logic                w_one_side;
  logic signed [W:0]   w_inv_ext;
  logic signed [W:0]   w_post;
  logic                w_over;
  logic                w_drop;

  assign w_one_side = bus.dec_buy ^ bus.dec_sell;
  assign w_inv_ext  = {r_inv[W-1], r_inv};

  // Post-trade position is one bit wider so +/-ORDER_QTY cannot overflow.
  always_comb begin
    w_post = (r_side == SIDE_BUY) ? (w_inv_ext + P_QTY) : (w_inv_ext - P_QTY);
    w_over = (w_post > P_LIM) || (w_post < -P_LIM);
  end

  // A limit reject and a late decision in the same CHECK cycle still count once.
  always_comb begin
    w_drop = 1'b0;
    case (r_state)
      ST_IDLE:  w_drop = bus.dec_valid & (bus.dec_buy | bus.dec_sell)
                         & ((bus.dec_buy & bus.dec_sell) | bus.kill);
      ST_CHECK: w_drop = w_over | (bus.dec_valid & w_one_side);
      default:  w_drop = bus.dec_valid & w_one_side;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_side      <= SIDE_SELL;
      r_px        <= '0;
      r_inv       <= '0;
      r_cool      <= '0;
      r_ord_valid <= 1'b0;
      r_ord_side  <= 1'b0;
      r_ord_px    <= '0;
      r_ord_qty   <= '0;
      r_ord_id    <= '0;
      r_busy      <= 1'b0;
      r_drop      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.dec_valid && w_one_side && !bus.kill) begin
            r_side  <= bus.dec_buy ? SIDE_BUY : SIDE_SELL;
            r_px    <= bus.dec_buy ? bus.ask_px0 : bus.bid_px0;
            r_inv   <= bus.inventory;
            r_state <= ST_CHECK;
            r_busy  <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_over) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state     <= ST_SEND;
            r_ord_valid <= 1'b1;
            r_ord_side  <= r_side;
            r_ord_px    <= r_px;
            r_ord_qty   <= QTY_W'(ORDER_QTY);
          end
        end
        ST_SEND: begin
          if (bus.ord_ready) begin
            r_ord_valid <= 1'b0;
            r_ord_id    <= r_ord_id + ID_W'(1);
            if (COOLDOWN == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_COOL;
              r_cool  <= CW'(COOLDOWN);
            end
          end
        end
        ST_COOL: begin
          if (r_cool <= CW'(1)) begin
            r_cool  <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cool <= r_cool - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 16'd1;
    end
  end

  assign bus.ord_valid = r_ord_valid;
  assign bus.ord_side  = r_ord_side;
  assign bus.ord_px    = r_ord_px;
  assign bus.ord_qty   = r_ord_qty;
  assign bus.ord_id    = r_ord_id;
  assign bus.busy      = r_busy;
  assign bus.drop_cnt  = r_drop;

endmodule

// File: tb/tb_order_gen.sv
// Directed self-checking bench for order_gen: latency, backpressure, risk limits, drops, ID wrap, reset.
module tb_order_gen;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  order_gen_if #(.W(32), .QTY_W(16), .ID_W(16)) bus ();
  order_gen_if #(.W(32), .QTY_W(16), .ID_W(4))  bus_w ();

  order_gen #(
    .W(32), .QTY_W(16), .ID_W(16), .ORDER_QTY(1), .MAX_POS(1000), .COOLDOWN(8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  order_gen #(
    .W(32), .QTY_W(16), .ID_W(4), .ORDER_QTY(1), .MAX_POS(1000), .COOLDOWN(0)
  ) u_dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decide(input logic buy, input logic sell, input logic [31:0] bid,
                        input logic [31:0] ask, input int inv);
    bus.dec_valid = 1'b1;
    bus.dec_buy   = buy;
    bus.dec_sell  = sell;
    bus.bid_px0   = bid;
    bus.ask_px0   = ask;
    bus.inventory = inv;
  endtask

  task automatic release_dec();
    bus.dec_valid = 1'b0;
    bus.dec_buy   = 1'b0;
    bus.dec_sell  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50 && bus.busy; i++) tick();
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%0b required 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    release_dec();
    bus.bid_px0 = '0; bus.ask_px0 = '0; bus.inventory = '0; bus.kill = 1'b0; bus.ord_ready = 1'b0;
    bus_w.dec_valid = 1'b0; bus_w.dec_buy = 1'b0; bus_w.dec_sell = 1'b0;
    bus_w.bid_px0 = '0; bus_w.ask_px0 = '0; bus_w.inventory = '0; bus_w.kill = 1'b0;
    bus_w.ord_ready = 1'b1;
    repeat (2) tick();
    tests++;
    if ({bus.ord_valid, bus.ord_side, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: valid/side/busy=%b required 000",
               {bus.ord_valid, bus.ord_side, bus.busy});
    end
    tests++;
    if (bus.ord_px !== 32'd0 || bus.ord_qty !== 16'd0 || bus.ord_id !== 16'd0) begin
      fails++;
      $display("FAIL reset_fields: px=%0d qty=%0d id=%0d required 0 0 0",
               bus.ord_px, bus.ord_qty, bus.ord_id);
    end
    tests++;
    if (bus.drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_drop: got %0d required 0", bus.drop_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_buy_basic();
    int busy_cycles;
    bus.ord_ready = 1'b1;
    decide(1'b1, 1'b0, 32'd10000, 32'd10050, 0);
    tick();
    release_dec();
    bus.ask_px0 = 32'd77;
    tests++;
    if (bus.ord_valid !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL buy_n1: valid=%0b busy=%0b required 0 1", bus.ord_valid, bus.busy);
    end
    tick();
    tests++;
    if (bus.ord_valid !== 1'b1) begin
      fails++;
      $display("FAIL buy_latency: valid=%0b required 1", bus.ord_valid);
    end
    tests++;
    if (bus.ord_side !== 1'b1 || bus.ord_px !== 32'd10050 || bus.ord_qty !== 16'd1 ||
        bus.ord_id !== 16'd0) begin
      fails++;
      $display("FAIL buy_fields: side=%0b px=%0d qty=%0d id=%0d required 1 10050 1 0",
               bus.ord_side, bus.ord_px, bus.ord_qty, bus.ord_id);
    end
    busy_cycles = 2;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.busy) break;
      busy_cycles++;
    end
    tests++;
    if (busy_cycles != 10) begin
      fails++;
      $display("FAIL buy_busy_len: got %0d required 10", busy_cycles);
    end
    tests++;
    if (bus.ord_id !== 16'd1 || bus.ord_valid !== 1'b0) begin
      fails++;
      $display("FAIL buy_after: id=%0d valid=%0b required 1 0", bus.ord_id, bus.ord_valid);
    end
  endtask

  task automatic test_sell_backpressure();
    int bad;
    bus.ord_ready = 1'b0;
    decide(1'b0, 1'b1, 32'd9990, 32'd10100, 0);
    tick();
    release_dec();
    bus.bid_px0 = 32'd1234;
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ord_valid !== 1'b1 || bus.ord_side !== 1'b0 || bus.ord_px !== 32'd9990 ||
          bus.ord_qty !== 16'd1 || bus.ord_id !== 16'd1) bad++;
      if (i < 4) tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL sell_hold: %0d unstable cycles required 0 (valid=%0b px=%0d id=%0d)",
               bad, bus.ord_valid, bus.ord_px, bus.ord_id);
    end
    bus.ord_ready = 1'b1;
    tick();
    tests++;
    if (bus.ord_valid !== 1'b0 || bus.ord_id !== 16'd2) begin
      fails++;
      $display("FAIL sell_handshake: valid=%0b id=%0d required 0 2", bus.ord_valid, bus.ord_id);
    end
    wait_idle("sell");
  endtask

  task automatic test_limits();
    bus.ord_ready = 1'b1;
    decide(1'b1, 1'b0, 32'd100, 32'd101, 1000);
    tick();
    release_dec();
    tick();
    tests++;
    if (bus.drop_cnt !== 16'd1 || bus.ord_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL limit_long: drop=%0d valid=%0b busy=%0b required 1 0 0",
               bus.drop_cnt, bus.ord_valid, bus.busy);
    end
    decide(1'b0, 1'b1, 32'd100, 32'd101, -1000);
    tick();
    release_dec();
    tick();
    tests++;
    if (bus.drop_cnt !== 16'd2 || bus.ord_valid !== 1'b0) begin
      fails++;
      $display("FAIL limit_short: drop=%0d valid=%0b required 2 0", bus.drop_cnt, bus.ord_valid);
    end
    decide(1'b1, 1'b0, 32'd100, 32'd101, 999);
    tick();
    release_dec();
    tick();
    tests++;
    if (bus.ord_valid !== 1'b1 || bus.ord_px !== 32'd101 || bus.ord_id !== 16'd2 ||
        bus.drop_cnt !== 16'd2) begin
      fails++;
      $display("FAIL limit_edge_ok: valid=%0b px=%0d id=%0d drop=%0d required 1 101 2 2",
               bus.ord_valid, bus.ord_px, bus.ord_id, bus.drop_cnt);
    end
    wait_idle("limit");
  endtask

  task automatic test_drops();
    bus.ord_ready = 1'b1;
    decide(1'b1, 1'b0, 32'd500, 32'd505, 0);
    tick();
    release_dec();
    tick();
    tick();
    decide(1'b1, 1'b0, 32'd500, 32'd505, 0);
    tick();
    release_dec();
    tests++;
    if (bus.drop_cnt !== 16'd3 || bus.ord_valid !== 1'b0) begin
      fails++;
      $display("FAIL drop_in_cool: drop=%0d valid=%0b required 3 0", bus.drop_cnt, bus.ord_valid);
    end
    wait_idle("drops");
    bus.kill = 1'b1;
    decide(1'b1, 1'b0, 32'd500, 32'd505, 0);
    tick();
    release_dec();
    bus.kill = 1'b0;
    tests++;
    if (bus.drop_cnt !== 16'd4 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_kill: drop=%0d busy=%0b required 4 0", bus.drop_cnt, bus.busy);
    end
    decide(1'b1, 1'b1, 32'd500, 32'd505, 0);
    tick();
    release_dec();
    tests++;
    if (bus.drop_cnt !== 16'd5 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_both_sides: drop=%0d busy=%0b required 5 0", bus.drop_cnt, bus.busy);
    end
    decide(1'b0, 1'b0, 32'd500, 32'd505, 0);
    tick();
    release_dec();
    tick();
    tests++;
    if (bus.drop_cnt !== 16'd5 || bus.busy !== 1'b0 || bus.ord_id !== 16'd4) begin
      fails++;
      $display("FAIL drop_no_side: drop=%0d busy=%0b id=%0d required 5 0 4",
               bus.drop_cnt, bus.busy, bus.ord_id);
    end
  endtask

  task automatic test_reset_in_send();
    bus.ord_ready = 1'b0;
    decide(1'b1, 1'b0, 32'd300, 32'd301, 0);
    tick();
    release_dec();
    tick();
    tests++;
    if (bus.ord_valid !== 1'b1 || bus.ord_id !== 16'd4) begin
      fails++;
      $display("FAIL rst_pre_send: valid=%0b id=%0d required 1 4", bus.ord_valid, bus.ord_id);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.ord_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ord_id !== 16'd0 ||
        bus.drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rst_async: valid=%0b busy=%0b id=%0d drop=%0d required 0 0 0 0",
               bus.ord_valid, bus.busy, bus.ord_id, bus.drop_cnt);
    end
    #2 rst = 1'b0;
    tick();
    bus.ord_ready = 1'b1;
    decide(1'b1, 1'b0, 32'd300, 32'd302, 0);
    tick();
    release_dec();
    tick();
    tests++;
    if (bus.ord_valid !== 1'b1 || bus.ord_id !== 16'd0 || bus.ord_px !== 32'd302) begin
      fails++;
      $display("FAIL rst_next_order: valid=%0b id=%0d px=%0d required 1 0 302",
               bus.ord_valid, bus.ord_id, bus.ord_px);
    end
    wait_idle("rst");
  endtask

  task automatic test_id_wrap();
    int bad;
    logic [3:0] exp_id;
    bad = 0;
    for (int k = 0; k < 17; k++) begin
      exp_id = 4'(k);
      bus_w.dec_valid = 1'b1;
      bus_w.dec_buy   = 1'b1;
      bus_w.ask_px0   = 32'(k + 20);
      tick();
      bus_w.dec_valid = 1'b0;
      bus_w.dec_buy   = 1'b0;
      tick();
      if (k >= 15) begin
        tests++;
        if (bus_w.ord_valid !== 1'b1 || bus_w.ord_id !== exp_id) begin
          fails++;
          $display("FAIL id_wrap_%0d: valid=%0b id=%0d required 1 %0d",
                   k, bus_w.ord_valid, bus_w.ord_id, exp_id);
        end
      end else if (bus_w.ord_valid !== 1'b1 || bus_w.ord_id !== exp_id) begin
        bad++;
      end
      tick();
      if (bus_w.busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL id_sequence: %0d bad orders required 0", bad);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_buy_basic();
    test_sell_backpressure();
    test_limits();
    test_drops();
    test_reset_in_send();
    test_id_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
